// File: rtl/uart_pkg.sv
// Shared UART constants and receive-FSM state encoding, used by both RX and TX sides.
package uart_pkg;

  localparam int unsigned WordLengthDef = 8;
  localparam int unsigned OversampleDef = 16;
  localparam int unsigned TickDivDef    = 13;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick divider: pulses tick once every TICK_DIV clk cycles; clear restarts the count.
module uart_rx_tick_gen #(
  parameter int unsigned TICK_DIV = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt;

  assign tick = (cnt == CntLast);

  always_ff @(posedge clk) begin
    if (reset || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: 2-flop synchronizer, mid-bit oversampled FSM, LSB-first shift register.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = WordLengthDef,
  parameter int unsigned OVERSAMPLE  = OversampleDef,
  parameter int unsigned TICK_DIV    = TickDivDef
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_flag,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(WORD_LENGTH + 1);
  localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] FullLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WORD_LENGTH - 1);

  uart_rx_state_e         state;
  logic                   rx_m, rx_s, rx_p;
  logic                   tick;
  logic                   frame_err_n;
  logic [TickW-1:0]       tick_cnt;
  logic [BitW-1:0]        bit_cnt;
  logic [WORD_LENGTH-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bit;
`endif

  // Divider is held cleared while idle so the first tick lands TICK_DIV cycles after the edge.
  uart_rx_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(state == StIdle),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      rx_p        <= 1'b1;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      frame_err_n <= 1'b0;
      rx_data     <= '0;
      rx_flag     <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit  <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_p    <= rx_s;
      rx_flag <= 1'b0;
      case (state)
        StIdle: begin
          if (rx_p && !rx_s) begin
            state    <= StStart;
            busy     <= 1'b1;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        StStart: begin
          if (tick) begin
            if (tick_cnt == HalfLast) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state <= StData;
              end else begin
                state <= StIdle;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        StData: begin
          if (tick) begin
            if (tick_cnt == FullLast) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[WORD_LENGTH-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == BitLast) begin
`ifdef UART_RX_PARITY_EN
                state <= StParity;
`else
                state <= StStop;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (tick) begin
            if (tick_cnt == FullLast) begin
              tick_cnt   <= '0;
              parity_bit <= rx_s;
              state      <= StStop;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        StStop: begin
          if (tick) begin
            if (tick_cnt == FullLast) begin
              tick_cnt    <= '0;
              frame_err_n <= ~rx_s;
              state       <= StDone;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        StDone: begin
          rx_data    <= shreg;
          frame_err  <= frame_err_n;
`ifdef UART_RX_PARITY_EN
          parity_err <= ^{shreg, parity_bit};
`endif
          rx_flag    <= 1'b1;
          busy       <= 1'b0;
          state      <= StIdle;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm at default parameters (bit period 208 clk).
module tb_uart_rx_fsm;

  localparam int unsigned Bit = 208;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_flag, frame_err, parity_err, busy;

  always #5 clk = ~clk;

  uart_rx_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_flag   (rx_flag),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Flag monitor: records each received frame as seen in the rx_flag cycle.
  int         flag_count = 0;
  int         double_flag = 0;
  logic       prev_flag = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] f_data [16];
  logic       f_ferr [16];
  logic       f_perr [16];
  logic       f_busy [16];
  logic       f_bprev[16];

  always @(negedge clk) begin
    if (rx_flag) begin
      if (prev_flag) double_flag <= double_flag + 1;
      if (flag_count < 16) begin
        f_data[flag_count]  <= rx_data;
        f_ferr[flag_count]  <= frame_err;
        f_perr[flag_count]  <= parity_err;
        f_busy[flag_count]  <= busy;
        f_bprev[flag_count] <= prev_busy;
      end
      flag_count <= flag_count + 1;
    end
    prev_flag <= rx_flag;
    prev_busy <= busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (Bit) @(negedge clk);
  endtask

  task automatic send_data(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_data(d);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par, input logic stop);
    send_data(d);
    send_bit(par);
    send_bit(stop);
  endtask
`endif

  int base;

  initial begin
    repeat (5) @(negedge clk);
    check_eq("rst_rx_data", {24'd0, rx_data}, 32'h0);
    check_eq("rst_rx_flag", {31'd0, rx_flag}, 32'h0);
    check_eq("rst_frame_err", {31'd0, frame_err}, 32'h0);
    check_eq("rst_parity_err", {31'd0, parity_err}, 32'h0);
    check_eq("rst_busy", {31'd0, busy}, 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Clean frame 0xA5
    base = flag_count;
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("a5_flags", flag_count, base + 1);
    check_eq("a5_data", {24'd0, f_data[base]}, 32'hA5);
    check_eq("a5_ferr", {31'd0, f_ferr[base]}, 32'h0);
    check_eq("a5_busy_before_flag", {31'd0, f_bprev[base]}, 32'h1);
    check_eq("a5_busy_at_flag", {31'd0, f_busy[base]}, 32'h0);
    check_eq("a5_perr", {31'd0, f_perr[base]}, 32'h0);

    // Start-bit glitch: 50 clk low
    base = flag_count;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("glitch_busy_high", {31'd0, busy}, 32'h1);
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (65) @(negedge clk);
    check_eq("glitch_busy_low", {31'd0, busy}, 32'h0);
    repeat (300) @(negedge clk);
    check_eq("glitch_no_flag", flag_count, base);
    check_eq("glitch_data_held", {24'd0, rx_data}, 32'hA5);

    // Framing error, line then held low
    base = flag_count;
    send_frame(8'h3C, 1'b0);
    repeat (1000) @(negedge clk);
    check_eq("3c_flags", flag_count, base + 1);
    check_eq("3c_data", {24'd0, f_data[base]}, 32'h3C);
    check_eq("3c_ferr", {31'd0, f_ferr[base]}, 32'h1);
    check_eq("3c_frame_err_port", {31'd0, frame_err}, 32'h1);
    check_eq("low_line_idle", {31'd0, busy}, 32'h0);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("low_line_no_retrigger", flag_count, base + 1);

    // Reset in the middle of 0x55
    base = flag_count;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check_eq("mid_busy", {31'd0, busy}, 32'h1);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_data", {24'd0, rx_data}, 32'h0);
    check_eq("mid_rst_ferr", {31'd0, frame_err}, 32'h0);
    check_eq("mid_rst_flag", {31'd0, rx_flag}, 32'h0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("81_flags", flag_count, base + 1);
    check_eq("81_data", {24'd0, f_data[base]}, 32'h81);
    check_eq("81_ferr", {31'd0, f_ferr[base]}, 32'h0);

    // Back-to-back frames
    base = flag_count;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("b2b_flags", flag_count, base + 2);
    check_eq("b2b_data0", {24'd0, f_data[base]}, 32'h00);
    check_eq("b2b_ferr0", {31'd0, f_ferr[base]}, 32'h0);
    check_eq("b2b_data1", {24'd0, f_data[base+1]}, 32'hFF);
    check_eq("b2b_ferr1", {31'd0, f_ferr[base+1]}, 32'h0);

`ifdef UART_RX_PARITY_EN
    base = flag_count;
    send_frame_par(8'h07, 1'b1, 1'b1);
    send_frame_par(8'h07, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("par_flags", flag_count, base + 2);
    check_eq("par_ok_perr", {31'd0, f_perr[base]}, 32'h0);
    check_eq("par_bad_perr", {31'd0, f_perr[base+1]}, 32'h1);
    check_eq("par_bad_data", {24'd0, f_data[base+1]}, 32'h07);
    check_eq("par_bad_port", {31'd0, parity_err}, 32'h1);
`else
    check_eq("noparity_port", {31'd0, parity_err}, 32'h0);
    check_eq("noparity_ff_perr", {31'd0, f_perr[base+1]}, 32'h0);
`endif

    check_eq("flag_single_cycle", double_flag, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
